// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_addsub_pkg;

  // Legal operand widths.
  localparam int W_MIN = 2;
  localparam int W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub.
// Latency: n/a (wires only).
// Backpressure: none; start is taken only when the block is not busy.
// Ports: start/sub/a/b driven by the requester (master); busy/done/sum/cout/ovf
//        driven by the block (slave).
interface serial_addsub_if #(
  parameter int W = 8
);
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_fa_bit.sv
// 1-bit full-adder cell, purely combinational.
// Latency: 0 cycles.
// Backpressure: n/a.
// Ports: a, b, cin in; sum, cout out.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial W-bit add/subtract, one bit per cycle LSB first.
// Latency: done pulses W cycles after the accept edge; throughput W+1 cycles.
// Backpressure: start is ignored while busy; accepted in IDLE or DONE.
// Ports: clk, rst_n (async active-low); bus = serial_addsub_if.slave
//        (start/sub/a/b in, busy/done/sum/cout/ovf out).
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("serial_addsub: W=%0d outside legal range", W);
  end

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          fa_sum;
  logic          fa_cout;
  logic          accept;
  logic          last_bit;

  // Subtraction is a + ~b + 1: b is inverted per bit and the +1 comes from
  // the carry being preset to sub on the accept edge.
  fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0] ^ sub_q),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept   = bus.start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      sub_d   = bus.sub;
      carry_d = bus.sub;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      // a doubles as the result shifter: each sum bit enters at the MSB as
      // the consumed operand bit leaves at the LSB.
      a_d     = {fa_sum, a_q[W-1:1]};
      b_d     = {1'b0, b_q[W-1:1]};
      carry_d = fa_cout;
      // Counter parks at the terminal count rather than wrapping.
      if (!last_bit) cnt_d = cnt_q + 1'b1;
      if (last_bit) begin
        sum_d  = {fa_sum, a_q[W-1:1]};
        cout_d = fa_cout;
        // carry_q is the carry into the MSB at this point.
        ovf_d  = carry_q ^ fa_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at W=8 plus an exhaustive W=4 sweep.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n8;
  logic rst_n4;

  serial_addsub_if #(.W(8)) if8 ();
  serial_addsub_if #(.W(4)) if4 ();

  serial_addsub #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n8), .bus(if8));
  serial_addsub #(.W(4)) u_dut4 (.clk(clk), .rst_n(rst_n4), .bus(if4));

  int tests = 0;
  int fails = 0;

  logic [7:0] held_sum;
  logic       held_cout;
  logic       held_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an op at a falling edge; returns at the falling edge after accept.
  task automatic go8(input logic s, input logic [7:0] x, input logic [7:0] y);
    if8.start = 1'b1;
    if8.sub   = s;
    if8.a     = x;
    if8.b     = y;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    if8.sub   = ~s;
    if8.a     = ~x;
    if8.b     = x ^ y;
  endtask

  // Checks busy/done and result hold for each bit-cycle, then the result.
  // poke_at >= 0 raises start with other operands at that bit-cycle.
  task automatic finish8(input string tag, input logic [7:0] es, input logic ec,
                         input logic eo, input int poke_at);
    for (int j = 0; j < 8; j++) begin
      check({tag, " busy"}, 64'(if8.busy), 64'(1'b1));
      check({tag, " done early"}, 64'(if8.done), 64'(1'b0));
      check({tag, " sum hold"}, 64'(if8.sum), 64'(held_sum));
      if (j == poke_at) begin
        if8.start = 1'b1;
        if8.sub   = 1'b1;
        if8.a     = 8'hAA;
        if8.b     = 8'h55;
      end else begin
        if8.start = 1'b0;
      end
      @(negedge clk);
    end
    if8.start = 1'b0;
    check({tag, " done"}, 64'(if8.done), 64'(1'b1));
    check({tag, " busy end"}, 64'(if8.busy), 64'(1'b0));
    check({tag, " sum"}, 64'(if8.sum), 64'(es));
    check({tag, " cout"}, 64'(if8.cout), 64'(ec));
    check({tag, " ovf"}, 64'(if8.ovf), 64'(eo));
    held_sum  = es;
    held_cout = ec;
    held_ovf  = eo;
  endtask

  // One idle cycle after done: pulse must be gone, results held.
  task automatic idle8(input string tag);
    @(negedge clk);
    check({tag, " done gone"}, 64'(if8.done), 64'(1'b0));
    check({tag, " idle busy"}, 64'(if8.busy), 64'(1'b0));
    check({tag, " sum held"}, 64'(if8.sum), 64'(held_sum));
    check({tag, " cout held"}, 64'(if8.cout), 64'(held_cout));
    check({tag, " ovf held"}, 64'(if8.ovf), 64'(held_ovf));
  endtask

  initial begin
    logic [3:0] x4, y4, yy;
    logic [4:0] full;
    logic       eovf;
    logic [4:0] bpat, dpat;

    rst_n8 = 1'b0;
    rst_n4 = 1'b0;
    if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0;
    if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;

    #12;
    check("rst busy", 64'(if8.busy), 64'(1'b0));
    check("rst done", 64'(if8.done), 64'(1'b0));
    check("rst sum", 64'(if8.sum), 64'(8'h00));
    check("rst cout", 64'(if8.cout), 64'(1'b0));
    check("rst ovf", 64'(if8.ovf), 64'(1'b0));

    @(negedge clk);
    rst_n8 = 1'b1;
    rst_n4 = 1'b1;

    // First start taken on the first rising edge after reset release.
    go8(1'b0, 8'h7F, 8'h01);
    finish8("add 7F+01", 8'h80, 1'b0, 1'b1, -1);
    idle8("add 7F+01");

    go8(1'b0, 8'hFF, 8'h01);
    finish8("add FF+01", 8'h00, 1'b1, 1'b0, -1);
    idle8("add FF+01");

    go8(1'b1, 8'h05, 8'h07);
    finish8("sub 05-07", 8'hFE, 1'b0, 1'b0, -1);
    idle8("sub 05-07");

    // Back-to-back: second start issued in the DONE cycle.
    go8(1'b1, 8'h80, 8'h01);
    finish8("sub 80-01", 8'h7F, 1'b1, 1'b1, -1);
    go8(1'b0, 8'h12, 8'h34);
    finish8("b2b 12+34", 8'h46, 1'b0, 1'b0, -1);
    idle8("b2b 12+34");

    // Start re-asserted mid-run with other operands must be ignored.
    go8(1'b0, 8'h3C, 8'h0F);
    finish8("poke 3C+0F", 8'h4B, 1'b0, 1'b0, 3);
    idle8("poke 3C+0F");

    // Reset in the middle of a run.
    go8(1'b1, 8'h10, 8'h20);
    for (int j = 0; j < 4; j++) begin
      check("pre-rst busy", 64'(if8.busy), 64'(1'b1));
      @(negedge clk);
    end
    rst_n8 = 1'b0;
    #1;
    check("midrst busy", 64'(if8.busy), 64'(1'b0));
    check("midrst done", 64'(if8.done), 64'(1'b0));
    check("midrst sum", 64'(if8.sum), 64'(8'h00));
    check("midrst cout", 64'(if8.cout), 64'(1'b0));
    check("midrst ovf", 64'(if8.ovf), 64'(1'b0));
    @(negedge clk);
    rst_n8 = 1'b1;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("post-rst no done", 64'(if8.done), 64'(1'b0));
      check("post-rst no busy", 64'(if8.busy), 64'(1'b0));
    end
    go8(1'b1, 8'h10, 8'h20);
    finish8("sub 10-20", 8'hF0, 1'b0, 1'b0, -1);
    idle8("sub 10-20");

    // Exhaustive W=4 sweep, ops issued back-to-back from DONE.
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          x4   = 4'(x);
          y4   = 4'(y);
          yy   = (s != 0) ? ~y4 : y4;
          full = {1'b0, x4} + {1'b0, yy} + 5'(s);
          eovf = (x4[3] == yy[3]) && (full[3] != x4[3]);
          if4.start = 1'b1;
          if4.sub   = (s != 0);
          if4.a     = x4;
          if4.b     = y4;
          @(posedge clk);
          @(negedge clk);
          if4.start = 1'b0;
          if4.a     = ~x4;
          if4.b     = ~y4;
          for (int k = 0; k < 5; k++) begin
            bpat[k] = if4.busy;
            dpat[k] = if4.done;
            if (k < 4) @(negedge clk);
          end
          check($sformatf("w4 s%0d %0h,%0h busy", s, x, y), 64'(bpat), 64'(5'b01111));
          check($sformatf("w4 s%0d %0h,%0h done", s, x, y), 64'(dpat), 64'(5'b10000));
          check($sformatf("w4 s%0d %0h,%0h sum", s, x, y), 64'(if4.sum), 64'(full[3:0]));
          check($sformatf("w4 s%0d %0h,%0h cout", s, x, y), 64'(if4.cout), 64'(full[4]));
          check($sformatf("w4 s%0d %0h,%0h ovf", s, x, y), 64'(if4.ovf), 64'(eovf));
        end
      end
    end
    @(negedge clk);
    check("w4 final done gone", 64'(if4.done), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter W, default 8: operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a new operation; accepted only when state is not RUN.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  W  operand A, unsigned/two's complement; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 sum  output  W  result of the last completed operation.
REQ-011 cout  output  1  final carry out; in subtract mode, 1 = no borrow.
REQ-012 ovf  output  1  signed overflow of the last completed operation.

Function
REQ-013 The block SHALL compute one result bit per cycle, LSB first, through a 1-bit full-adder cell with a registered carry.
REQ-014 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after W bit-cycles; DONE->IDLE after one cycle, or DONE->RUN if start is high.
REQ-015 On the accept edge (edge 0), the block SHALL load the a and b shift registers, set carry to sub, clear the bit counter and enter RUN.
REQ-016 On edges 1..W, bit i = edge-1 SHALL be computed as a[i] + (b[i] XOR sub) + carry, with carry updated from the cell's cout.
REQ-017 On edge W, sum, cout and ovf SHALL be updated together and the state SHALL go to DONE.
REQ-018 done SHALL be high for exactly the one cycle following edge W.
REQ-019 busy SHALL be high from after edge 0 through edge W.
REQ-020 sum, cout and ovf SHALL hold their values until the next completion; partial results are never visible.
REQ-021 ovf SHALL equal the carry into bit W-1 XOR the carry out of bit W-1.
REQ-022 start while in RUN SHALL be ignored, with no effect on the operation in flight.
REQ-023 sub, a and b SHALL be ignored except on the accept edge.
REQ-024 start in DONE SHALL be accepted on that edge: back-to-back ops, with a throughput of W+1 cycles each.
REQ-025 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL NOT wrap within an operation; terminal count is W-1.
REQ-026 Arithmetic SHALL be modulo 2^W, with no saturation.

Reset
REQ-027 rst_n low SHALL, asynchronously, force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear carry, counter and shift registers.
REQ-028 Reset mid-operation SHALL abort the operation; no done pulse follows and the result registers read zero.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package serial_addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the W legal-range constants.
REQ-031 The per-bit logic SHALL be a sub-module fa_bit (ports a, b, cin, sum, cout); it is purely combinational.
REQ-032 The top SHALL contain the FSM, the counter, the shift registers, the carry flop and the result registers.
REQ-033 An elaboration-time check SHALL reject W outside 2..64.

Verification
REQ-034 W=8, add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; done exactly 8 edges after the accept edge, for exactly one cycle.
REQ-035 W=8, add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0.
REQ-036 W=8, sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1; back-to-back second op started in DONE completes W+1 cycles after the first.
REQ-037 W=8, start pulsed again at bit 3 of a run with different a/b -> ignored; original result delivered and a single done pulse.
REQ-038 W=8, rst_n low at bit 4 -> immediate IDLE, outputs zero, no done pulse; a fresh op afterwards is correct.
REQ-039 W=4, exhaustive a, b and sub (512 ops) -> sum, cout and ovf match a reference model; busy/done timing checked each op.
